// File: rtl/tl45_decode_q.sv
// tl45_decode_q: decodes one 32-bit TL45 instruction per cycle into a micro-op
// and buffers it in a DEPTH-entry FIFO between fetch and operand/execute.
// Both sides use valid/ready handshakes. A decode error raises a sticky, precise
// trap that captures the faulting PC and word. Only i_flush or reset clears it.
//
// Configuration macro:
//   TL45_DECODE_STRICT_EN  defined   -> full per-opcode field checking
//                          undefined -> only unknown opcodes / nonzero NOP trap
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_flush                  synchronous flush: empties FIFO, clears trap
//   i_valid/o_ready          fetch handshake carrying i_pc, i_inst
//   o_valid/i_ready          downstream handshake for the head entry
//   o_pc .. o_imm            decoded head entry (all zero when o_valid=0)
//   o_count                  FIFO occupancy
//   o_decode_err, o_err_pc, o_err_inst   sticky trap state
module tl45_decode_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [PC_W-1:0]        i_pc,
  input  logic [31:0]            i_inst,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [PC_W-1:0]        o_pc,
  output logic [4:0]             o_opcode,
  output logic                   o_ri,
  output logic [3:0]             o_dr,
  output logic [3:0]             o_sr1,
  output logic [3:0]             o_sr2,
  output logic [31:0]            o_imm,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_decode_err,
  output logic [PC_W-1:0]        o_err_pc,
  output logic [31:0]            o_err_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      opcode;
    logic            ri;
    logic [3:0]      dr;
    logic [3:0]      sr1;
    logic [3:0]      sr2;
    logic [31:0]     imm;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             dec;
  entry_t             head_e;
  logic               dec_err;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               err;
  logic [PC_W-1:0]    err_pc;
  logic [31:0]        err_inst;
  logic               full;
  logic               accept;
  logic               push;
  logic               pop;

  // Handshake status derives from registered state only (no i_ready path).
  assign full    = (count == CNT_W'(DEPTH));
  assign o_ready = !full && !err;
  assign o_valid = (count != '0);
  assign accept  = i_valid && o_ready;
  assign push    = accept && !dec_err;
  assign pop     = o_valid && i_ready;

  // Field split, immediate resolution and register-specifier reordering.
  always_comb begin
    dec        = '0;
    dec.pc     = i_pc;
    dec.opcode = i_inst[31:27];
    dec.ri     = i_inst[26];
    dec.dr     = i_inst[23:20];
    dec.sr1    = i_inst[19:16];
    case (i_inst[25:24])
      2'b00:   dec.imm = {16'h0000, i_inst[15:0]};
      2'b01:   dec.imm = {{16{i_inst[15]}}, i_inst[15:0]};
      default: dec.imm = {i_inst[15:0], 16'h0000};
    endcase
    if (dec.opcode == 5'h0D || dec.opcode == 5'h0E) begin
      dec.sr2 = 4'hF;
    end else if (dec.opcode == 5'h13 || dec.opcode == 5'h15) begin
      // Stores carry their data register in the sr2 slot.
      dec.sr2 = i_inst[23:20];
      dec.dr  = 4'h0;
    end else if (i_inst[26]) begin
      dec.sr2 = 4'h0;
    end else begin
      dec.sr2 = i_inst[15:12];
    end
  end

  // Decode-error classification.
  always_comb begin
    dec_err = 1'b1;
`ifdef TL45_DECODE_STRICT_EN
    case (i_inst[31:27])
      5'h00:                      dec_err = (i_inst != 32'h0);
      5'h01, 5'h02, 5'h05,
      5'h0A, 5'h0B:               dec_err = i_inst[26] ? (i_inst[15:5] != '0)
                                                       : (i_inst[26:24] != 3'b000);
      5'h06, 5'h07, 5'h08:        dec_err = !i_inst[26] &&
                                            (i_inst[26:24] != 3'b000 || i_inst[11:0] != '0);
      5'h09:                      dec_err = (i_inst[26:24] != 3'b000) || (i_inst[11:0] != '0);
      5'h0C:                      dec_err = (i_inst[26:24] != 3'b101);
      5'h0D:                      dec_err = (i_inst[26:24] != 3'b000);
      5'h0E:                      dec_err = (i_inst[26:24] != 3'b000) || (i_inst[23:20] != 4'hF) ||
                                            (i_inst[19:16] != 4'h0) || (i_inst[15:0] != '0);
      5'h10:                      dec_err = (i_inst[26:24] != 3'b000) || (i_inst[19:16] != 4'h0);
      5'h11:                      dec_err = (i_inst[26:24] != 3'b000) || (i_inst[23:20] != 4'h0);
      5'h0F, 5'h12, 5'h13,
      5'h14, 5'h15:               dec_err = (i_inst[26:24] != 3'b001);
      default:                    dec_err = 1'b1;
    endcase
`else
    case (i_inst[31:27])
      5'h00:                      dec_err = (i_inst != 32'h0);
      5'h01, 5'h02, 5'h05, 5'h06,
      5'h07, 5'h08, 5'h09, 5'h0A,
      5'h0B, 5'h0C, 5'h0D, 5'h0E,
      5'h0F, 5'h10, 5'h11, 5'h12,
      5'h13, 5'h14, 5'h15:        dec_err = 1'b0;
      default:                    dec_err = 1'b1;
    endcase
`endif
  end

  // Entry storage; contents are don't-care until covered by count.
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) begin
      mem[tail] <= dec;
    end
  end

  // Pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Sticky trap capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err      <= 1'b0;
      err_pc   <= '0;
      err_inst <= '0;
    end else if (i_flush) begin
      err      <= 1'b0;
      err_pc   <= '0;
      err_inst <= '0;
    end else if (accept && dec_err) begin
      err      <= 1'b1;
      err_pc   <= i_pc;
      err_inst <= i_inst;
    end
  end

  assign o_decode_err = err;
  assign o_err_pc     = err_pc;
  assign o_err_inst   = err_inst;
  assign o_count      = count;
  assign head_e       = mem[head];

  // Head data reads as zero whenever the FIFO is empty.
  always_comb begin
    o_pc     = '0;
    o_opcode = '0;
    o_ri     = 1'b0;
    o_dr     = '0;
    o_sr1    = '0;
    o_sr2    = '0;
    o_imm    = '0;
    if (o_valid) begin
      o_pc     = head_e.pc;
      o_opcode = head_e.opcode;
      o_ri     = head_e.ri;
      o_dr     = head_e.dr;
      o_sr1    = head_e.sr1;
      o_sr2    = head_e.sr2;
      o_imm    = head_e.imm;
    end
  end

endmodule

// File: tb/tb_tl45_decode_q.sv
// tb_tl45_decode_q: directed plus randomized check of tl45_decode_q against a
// queue-based reference model of the decode/FIFO/trap behaviour.
module tb_tl45_decode_q;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  op;
    logic        ri;
    logic [3:0]  dr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] imm;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, in_valid, out_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            o_ready, o_valid, o_ri, o_decode_err;
  logic [PC_W-1:0] o_pc, o_err_pc;
  logic [4:0]      o_opcode;
  logic [3:0]      o_dr, o_sr1, o_sr2;
  logic [31:0]     o_imm, o_err_inst;
  logic [CW-1:0]   o_count;

  int total = 0;
  int bad   = 0;

  ent_t        q[$];
  bit          merr = 1'b0;
  logic [31:0] mepc = '0;
  logic [31:0] meinst = '0;

  always #5 clk = ~clk;

  tl45_decode_q #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_valid(in_valid), .o_ready(o_ready), .i_pc(in_pc), .i_inst(in_inst),
    .o_valid(o_valid), .i_ready(out_ready), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_ri(o_ri), .o_dr(o_dr), .o_sr1(o_sr1), .o_sr2(o_sr2), .o_imm(o_imm),
    .o_count(o_count), .o_decode_err(o_decode_err), .o_err_pc(o_err_pc),
    .o_err_inst(o_err_inst)
  );

  // Reference decode of one word, straight from the field rules.
  function automatic ent_t model_dec(input logic [31:0] pc, input logic [31:0] w);
    ent_t e;
    int unsigned op, ri, lh, zs, dr, s1, imm16;
    op = w >> 27; ri = (w >> 26) & 1; lh = (w >> 25) & 1; zs = (w >> 24) & 1;
    dr = (w >> 20) & 15; s1 = (w >> 16) & 15; imm16 = w & 32'hFFFF;
    e.pc = pc; e.op = 5'(op); e.ri = 1'(ri); e.s1 = 4'(s1); e.dr = 4'(dr);
    if (lh != 0)                     e.imm = imm16 * 65536;
    else if (zs != 0 && imm16 >= 32768) e.imm = imm16 + 32'hFFFF_0000;
    else                             e.imm = imm16;
    if (op == 13 || op == 14)        e.s2 = 4'hF;
    else if (op == 19 || op == 21) begin e.s2 = 4'(dr); e.dr = 4'h0; end
    else if (ri != 0)                e.s2 = 4'h0;
    else                             e.s2 = 4'((w >> 12) & 15);
    return e;
  endfunction

  function automatic bit model_err(input logic [31:0] w);
    int unsigned op, ri, mode, dr, s1, imm16, low;
    op = w >> 27; ri = (w >> 26) & 1; mode = (w >> 24) & 7;
    dr = (w >> 20) & 15; s1 = (w >> 16) & 15; imm16 = w & 32'hFFFF; low = w & 32'hFFF;
    if (op == 0) return w != 0;
`ifdef TL45_DECODE_STRICT_EN
    if (op inside {1, 2, 5, 10, 11}) return (ri != 0) ? (imm16 >= 32) : (mode != 0);
    if (op inside {6, 7, 8})         return ri == 0 && (mode != 0 || low != 0);
    if (op == 9)                     return mode != 0 || low != 0;
    if (op == 12)                    return mode != 5;
    if (op == 13)                    return mode != 0;
    if (op == 14)                    return mode != 0 || dr != 15 || s1 != 0 || imm16 != 0;
    if (op == 16)                    return mode != 0 || s1 != 0;
    if (op == 17)                    return mode != 0 || dr != 0;
    if (op inside {15, 18, 19, 20, 21}) return mode != 1;
    return 1'b1;
`else
    return !(op inside {1, 2, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21});
`endif
  endfunction

  // Word that is well formed even under strict checking.
  function automatic logic [31:0] gen_good();
    int unsigned ops[20] = '{0, 1, 2, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21};
    int unsigned op, ri, lh, zs, dr, s1, imm;
    op = ops[$urandom_range(19)]; ri = $urandom_range(1); lh = $urandom_range(1);
    zs = $urandom_range(1); dr = $urandom_range(15); s1 = $urandom_range(15);
    imm = $urandom_range(65535);
    case (op)
      0: return 32'h0;
      1, 2, 5, 10, 11: if (ri != 0) imm = imm % 32; else begin lh = 0; zs = 0; end
      6, 7, 8: if (ri == 0) begin lh = 0; zs = 0; imm = imm & 32'hF000; end
      9:  begin ri = 0; lh = 0; zs = 0; imm = imm & 32'hF000; end
      12: begin ri = 1; lh = 0; zs = 1; end
      13: begin ri = 0; lh = 0; zs = 0; end
      14: begin ri = 0; lh = 0; zs = 0; dr = 15; s1 = 0; imm = 0; end
      16: begin ri = 0; lh = 0; zs = 0; s1 = 0; end
      17: begin ri = 0; lh = 0; zs = 0; dr = 0; end
      default: begin ri = 0; lh = 0; zs = 1; end
    endcase
    return 32'((op << 27) | (ri << 26) | (lh << 25) | (zs << 24) | (dr << 20) | (s1 << 16) | imm);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = '{pc: '0, op: '0, ri: 1'b0, dr: '0, s1: '0, s2: '0, imm: '0};
    if (q.size() != 0) h = q[0];
    chk("valid", 64'(o_valid), 64'(q.size() != 0));
    chk("count", 64'(o_count), 64'(q.size()));
    chk("ready", 64'(o_ready), 64'(q.size() < DEPTH && !merr));
    chk("pc", 64'(o_pc), 64'(h.pc));
    chk("opcode", 64'(o_opcode), 64'(h.op));
    chk("ri", 64'(o_ri), 64'(h.ri));
    chk("dr", 64'(o_dr), 64'(h.dr));
    chk("sr1", 64'(o_sr1), 64'(h.s1));
    chk("sr2", 64'(o_sr2), 64'(h.s2));
    chk("imm", 64'(o_imm), 64'(h.imm));
    chk("decode_err", 64'(o_decode_err), 64'(merr));
    chk("err_pc", 64'(o_err_pc), 64'(mepc));
    chk("err_inst", 64'(o_err_inst), 64'(meinst));
  endtask

  // One clock cycle: drive at negedge, advance the model at the edge, check at next negedge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] w,
                      input bit rdy, input bit fl);
    bit pop_m, acc_m;
    in_valid = v; in_pc = pc; in_inst = w; out_ready = rdy; flush = fl;
    pop_m = (q.size() != 0) && rdy;
    acc_m = v && (q.size() < DEPTH) && !merr;
    @(posedge clk);
    if (fl) begin
      q.delete(); merr = 1'b0; mepc = '0; meinst = '0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (acc_m) begin
        if (model_err(w)) begin merr = 1'b1; mepc = pc; meinst = w; end
        else q.push_back(model_dec(pc, w));
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // ADD register form reaches the head one edge after acceptance.
    step(1, 32'h100, 32'h0812_3000, 0, 0);
    chk("add_opcode", 64'(o_opcode), 64'd1);
    chk("add_dr", 64'(o_dr), 64'd1);
    chk("add_sr1", 64'(o_sr1), 64'd2);
    chk("add_sr2", 64'(o_sr2), 64'd3);
    chk("add_imm", 64'(o_imm), 64'h3000);
    step(1, 32'h104, 32'hA830_0010, 1, 0);
    step(1, 32'h108, 32'h0E10_ABCD, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Fill, then pop and push concurrently; order must hold.
    step(0, 0, 0, 0, 1);
    step(1, 32'h200, 32'h0812_3000, 0, 0);
    step(1, 32'h204, 32'h1045_6000, 0, 0);
    step(1, 32'h208, 32'h3078_9000, 0, 0);
    step(1, 32'h20C, 32'h4812_0000, 0, 0);
    chk("full_count", 64'(o_count), 64'(DEPTH));
    chk("full_ready", 64'(o_ready), 64'd0);
    step(1, 32'h210, 32'h0834_5000, 1, 0);
    step(1, 32'h214, 32'h0856_7000, 1, 0);
    step(1, 32'h218, 32'h0878_9000, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

    // Trap behind two good entries; they drain, input stays refused.
    step(1, 32'h30, 32'h0812_3000, 0, 0);
    step(1, 32'h34, 32'h1045_6000, 0, 0);
    step(1, 32'h40, 32'hF800_0000, 0, 0);
    chk("trap_flag", 64'(o_decode_err), 64'd1);
    chk("trap_pc", 64'(o_err_pc), 64'h40);
    chk("trap_ready", 64'(o_ready), 64'd0);
    step(1, 32'h44, 32'h0812_3000, 1, 0);
    step(1, 32'h48, 32'h0812_3000, 1, 0);
    step(1, 32'h4C, 32'h0812_3000, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("flush_ready", 64'(o_ready), 64'd1);

    // JMP with mode 000: trap only under strict checking.
    step(1, 32'h50, 32'h6000_0000, 0, 0);
`ifdef TL45_DECODE_STRICT_EN
    chk("jmp_trap", 64'(o_decode_err), 64'd1);
`else
    chk("jmp_queued", 64'(o_opcode), 64'h0C);
`endif
    step(0, 0, 0, 0, 1);

    // Asynchronous reset with three entries queued.
    step(1, 32'h60, 32'h0812_3000, 0, 0);
    step(1, 32'h64, 32'h1045_6000, 0, 0);
    step(1, 32'h68, 32'h3078_9000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(o_valid), 64'd0);
    chk("async_count", 64'(o_count), 64'd0);
    q.delete(); merr = 1'b0; mepc = '0; meinst = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      bit fl;
      w  = ($urandom_range(3) != 0) ? gen_good() : $urandom;
      fl = merr ? ($urandom_range(7) == 0) : ($urandom_range(39) == 0);
      step($urandom_range(3) != 0, $urandom, w, 1'($urandom_range(1)), fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
